decode_execute_skid_stage: RTL and testbench
============================================

Name: decode_execute_skid_stage

Overview:
Parametrised decode-to-execute pipeline boundary. Replaces the fixed enable/clear flop with a valid/ready handshake and a 2-entry skid buffer. Execute can back-pressure decode without a combinational ready path, and a flush inserts bubbles. The block sits between the decode unit outputs and the execute unit inputs.

Parameters:
WIDTH, 36, data width of register contents and immediate
ADDRESSWIDTH, 4, register address width
OPCODEWIDTH, 4, opcode width
CTRLWIDTH, 8, control bundle width (write enables, selectors, ALU control)
COUNTWIDTH, 16, stall counter width (optional feature only)

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
flushE  in  1  synchronous flush; discard all held and incoming entries
validD  in  1  decode presents a valid entry
readyD  out  1  stage can accept an entry this cycle (registered)
reg1ContentD, reg2ContentD, inmmediateD  in  WIDTH each  operand data
regDestinationAddressD, reg1AddressD, reg2AddressD  in  ADDRESSWIDTH each  register addresses
opcodeD  in  OPCODEWIDTH  opcode
controlD  in  CTRLWIDTH  control bundle
reg1ContentE, reg2ContentE, inmmediateE  out  WIDTH each  registered operand data
regDestinationAddressE, reg1AddressE, reg2AddressE  out  ADDRESSWIDTH each  registered addresses
opcodeE  out  OPCODEWIDTH  registered opcode
controlE  out  CTRLWIDTH  registered control, forced to 0 when validE=0
validE  out  1  output entry valid
readyE  in  1  execute consumes the output entry this cycle

Behaviour:
- Payload is the concatenation of all D fields; the main register drives the E outputs; the skid register holds one overflow entry.
- Transfer in: validD & readyD. Transfer out: validE & readyE.
- readyD = ~skidValid, taken from a flop. No combinational path from readyE to readyD.
- States (main, skid valid): EMPTY(0,0), BUSY(1,0), FULL(1,1).
- EMPTY: validD -> BUSY, main <= D. Otherwise stays in EMPTY.
- BUSY, validD & readyE -> BUSY, main <= D.
- BUSY, validD & ~readyE -> FULL, skid <= D, main holds.
- BUSY, ~validD & readyE -> EMPTY.
- BUSY, ~validD & ~readyE -> holds.
- FULL: readyD=0, so input is ignored. readyE -> BUSY, main <= skid. ~readyE -> holds.
- Latency is 1 cycle from accept to validE. Sustained throughput is 1 entry/cycle when readyE=1.
- Ordering is strictly FIFO; there is no loss and no duplication.
- Output payload is stable while validE & ~readyE.
- flushE (priority over all): next state EMPTY, both payloads cleared to 0, validE=0, readyD=1. An entry presented in the same cycle is dropped.
- reset (asynchronous): EMPTY; all E outputs 0; validE=0; readyD=1; skid cleared.
- Releasing reset during validD=1 must not capture the entry until the first clock edge after deassertion.
- controlE = main.control & {CTRLWIDTH{validE}}. A bubble therefore never writes the register file or memory.

Optional Feature:
Macro DEXE_STALL_COUNT_EN.
- Defined: adds output stallCountE [COUNTWIDTH]. It increments each cycle validE & ~readyE, saturates at all-ones, and clears on reset or flushE.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then validD=1 and readyE=1 for 4 cycles with reg1ContentD=1..4 -> validE high from cycle 1; reg1ContentE=1,2,3,4 on consecutive cycles; readyD stays 1.
- BUSY holding entry A=0x5, readyE=0, validD=1 with B=0x6 -> FULL, readyD=0 next cycle, E shows 0x5. Raise readyE -> E=0x5 consumed, then E=0x6, then readyD=1.
- FULL, then flushE=1 with validD=1 (C=0x7) -> next cycle validE=0, all E fields 0, readyD=1; 0x7 never appears on E.
- Bubble: EMPTY with controlD=0xFF held but validD=0 -> controlE=0x00 and validE=0.
- Assert reset asynchronously mid-FULL (between edges) -> outputs 0 and readyD=1 immediately, without a clock edge.
- With DEXE_STALL_COUNT_EN and COUNTWIDTH=2, hold validE=1 and readyE=0 for 5 cycles -> stallCountE = 1,2,3,3,3; flushE -> 0.

Source files
------------

// File: rtl/decode_execute_skid_stage_if.sv
// -----------------------------------------------------------------------------
// decode_execute_skid_stage_if
//
// Bundles the decode-side (D) and execute-side (E) signals of the
// decode/execute pipeline boundary.
//   slave  : the view taken by the pipeline stage (consumes D, produces E)
//   master : the view taken by the surrounding pipeline / testbench
//
// D side : flushE, validD, readyD, reg1ContentD, reg2ContentD, inmmediateD,
//          regDestinationAddressD, reg1AddressD, reg2AddressD, opcodeD, controlD
// E side : validE, readyE, reg1ContentE, reg2ContentE, inmmediateE,
//          regDestinationAddressE, reg1AddressE, reg2AddressE, opcodeE, controlE
//
// Optional: when DEXE_STALL_COUNT_EN is defined the interface also carries
// stallCountE.
// -----------------------------------------------------------------------------
interface decode_execute_skid_stage_if #(
  parameter int WIDTH        = 36,
  parameter int ADDRESSWIDTH = 4,
  parameter int OPCODEWIDTH  = 4,
  parameter int CTRLWIDTH    = 8,
  parameter int COUNTWIDTH   = 16
);
  logic                    flushE;
  logic                    validD;
  logic                    readyD;
  logic [WIDTH-1:0]        reg1ContentD;
  logic [WIDTH-1:0]        reg2ContentD;
  logic [WIDTH-1:0]        inmmediateD;
  logic [ADDRESSWIDTH-1:0] regDestinationAddressD;
  logic [ADDRESSWIDTH-1:0] reg1AddressD;
  logic [ADDRESSWIDTH-1:0] reg2AddressD;
  logic [OPCODEWIDTH-1:0]  opcodeD;
  logic [CTRLWIDTH-1:0]    controlD;

  logic                    validE;
  logic                    readyE;
  logic [WIDTH-1:0]        reg1ContentE;
  logic [WIDTH-1:0]        reg2ContentE;
  logic [WIDTH-1:0]        inmmediateE;
  logic [ADDRESSWIDTH-1:0] regDestinationAddressE;
  logic [ADDRESSWIDTH-1:0] reg1AddressE;
  logic [ADDRESSWIDTH-1:0] reg2AddressE;
  logic [OPCODEWIDTH-1:0]  opcodeE;
  logic [CTRLWIDTH-1:0]    controlE;
`ifdef DEXE_STALL_COUNT_EN
  logic [COUNTWIDTH-1:0]   stallCountE;
`endif

  modport slave (
    input  flushE, validD, reg1ContentD, reg2ContentD, inmmediateD,
           regDestinationAddressD, reg1AddressD, reg2AddressD, opcodeD,
           controlD, readyE,
    output readyD, validE, reg1ContentE, reg2ContentE, inmmediateE,
           regDestinationAddressE, reg1AddressE, reg2AddressE, opcodeE,
           controlE
`ifdef DEXE_STALL_COUNT_EN
    , output stallCountE
`endif
  );

  modport master (
    output flushE, validD, reg1ContentD, reg2ContentD, inmmediateD,
           regDestinationAddressD, reg1AddressD, reg2AddressD, opcodeD,
           controlD, readyE,
    input  readyD, validE, reg1ContentE, reg2ContentE, inmmediateE,
           regDestinationAddressE, reg1AddressE, reg2AddressE, opcodeE,
           controlE
`ifdef DEXE_STALL_COUNT_EN
    , input stallCountE
`endif
  );
endinterface

// File: rtl/decode_execute_skid_stage.sv
// -----------------------------------------------------------------------------
// decode_execute_skid_stage
//
// Decode-to-execute pipeline register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). Execute back-pressure never reaches
// readyD combinationally: readyD comes straight from a flop. flushE turns
// the stage into a bubble on the next edge.
//
// Ports:
//   clock : pipeline clock
//   reset : asynchronous, active-high reset
//   bus   : decode_execute_skid_stage_if.slave (D inputs, E outputs,
//           validD/readyD and validE/readyE handshakes, flushE)
//
// Optional feature: define DEXE_STALL_COUNT_EN to add bus.stallCountE, a
// saturating count of cycles spent with validE & ~readyE.
// -----------------------------------------------------------------------------
module decode_execute_skid_stage #(
  parameter int WIDTH        = 36,
  parameter int ADDRESSWIDTH = 4,
  parameter int OPCODEWIDTH  = 4,
  parameter int CTRLWIDTH    = 8,
  parameter int COUNTWIDTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  decode_execute_skid_stage_if.slave    bus
);

  typedef struct packed {
    logic [WIDTH-1:0]        reg1_content;
    logic [WIDTH-1:0]        reg2_content;
    logic [WIDTH-1:0]        immediate;
    logic [ADDRESSWIDTH-1:0] dest_addr;
    logic [ADDRESSWIDTH-1:0] reg1_addr;
    logic [ADDRESSWIDTH-1:0] reg2_addr;
    logic [OPCODEWIDTH-1:0]  opcode;
    logic [CTRLWIDTH-1:0]    control;
  } payload_t;

  // Encoding is {main valid, skid valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t   state_q, state_d;
  payload_t main_q,  main_d;
  payload_t skid_q,  skid_d;
  logic     ready_q, ready_d;
  payload_t in_payload;
  logic     accept;

  assign in_payload = '{
    reg1_content: bus.reg1ContentD,
    reg2_content: bus.reg2ContentD,
    immediate:    bus.inmmediateD,
    dest_addr:    bus.regDestinationAddressD,
    reg1_addr:    bus.reg1AddressD,
    reg2_addr:    bus.reg2AddressD,
    opcode:       bus.opcodeD,
    control:      bus.controlD
  };

  assign accept = bus.validD & ready_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flushE) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_payload;
          end
        end
        BUSY: begin
          if (accept && bus.readyE) begin
            main_d = in_payload;
          end else if (accept) begin
            // Execute stalled: park the new entry behind the held one.
            state_d = FULL;
            skid_d  = in_payload;
          end else if (bus.readyE) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // readyD is low here, so decode cannot present anything.
          if (bus.readyE) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Registered ready: low exactly when the skid slot will be occupied.
    ready_d = (state_d != FULL);
  end

  // NOTE: the payload registers are reset (not left as don't-care storage)
  // because the E outputs must read zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.readyD                 = ready_q;
  assign bus.validE                 = state_q[1];
  assign bus.reg1ContentE           = main_q.reg1_content;
  assign bus.reg2ContentE           = main_q.reg2_content;
  assign bus.inmmediateE            = main_q.immediate;
  assign bus.regDestinationAddressE = main_q.dest_addr;
  assign bus.reg1AddressE           = main_q.reg1_addr;
  assign bus.reg2AddressE           = main_q.reg2_addr;
  assign bus.opcodeE                = main_q.opcode;
  // A bubble must never carry write enables into execute.
  assign bus.controlE               = main_q.control & {CTRLWIDTH{state_q[1]}};

`ifdef DEXE_STALL_COUNT_EN
  logic [COUNTWIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.flushE) begin
      stall_cnt_d = '0;
    end else if (state_q[1] && !bus.readyE && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stallCountE = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_execute_skid_stage.sv
module tb_decode_execute_skid_stage;
  localparam int W  = 36;
  localparam int AW = 4;
  localparam int OW = 4;
  localparam int CW = 8;
  localparam int NW = 2;
  localparam int PW = 3*W + 3*AW + OW + CW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  decode_execute_skid_stage_if #(
    .WIDTH(W), .ADDRESSWIDTH(AW), .OPCODEWIDTH(OW), .CTRLWIDTH(CW), .COUNTWIDTH(NW)
  ) bus ();

  decode_execute_skid_stage #(
    .WIDTH(W), .ADDRESSWIDTH(AW), .OPCODEWIDTH(OW), .CTRLWIDTH(CW), .COUNTWIDTH(NW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an ordered queue of at most two entries. The head is what
  // execute sees; decode may push only while fewer than two are held.
  logic [PW-1:0] model_q[$];
  logic [NW-1:0] model_cnt;
  logic [PW-1:0] cur_p;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [PW-1:0] obs_payload();
    return {bus.reg1ContentE, bus.reg2ContentE, bus.inmmediateE,
            bus.regDestinationAddressE, bus.reg1AddressE, bus.reg2AddressE,
            bus.opcodeE, bus.controlE};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mk(input logic [W-1:0] r1, input logic [CW-1:0] ctrl);
    logic [PW-1:0] p;
    p = rand_payload();
    p[PW-1 -: W] = r1;
    p[CW-1:0]    = ctrl;
    return p;
  endfunction

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic re, input logic fl);
    cur_p = p;
    {bus.reg1ContentD, bus.reg2ContentD, bus.inmmediateD,
     bus.regDestinationAddressD, bus.reg1AddressD, bus.reg2AddressD,
     bus.opcodeD, bus.controlD} = p;
    bus.validD = v;
    bus.readyE = re;
    bus.flushE = fl;
  endtask

  task automatic model_clear();
    model_q.delete();
    model_cnt = '0;
  endtask

  task automatic compare_all(input string tag);
    logic mv;
    mv = (model_q.size() > 0);
    check({tag, ".validE"}, bus.validE, mv);
    check({tag, ".readyD"}, bus.readyD, model_q.size() < 2);
    if (mv) check({tag, ".payload"}, obs_payload(), model_q[0]);
    else    check({tag, ".controlE"}, bus.controlE, '0);
`ifdef DEXE_STALL_COUNT_EN
    check({tag, ".stallCountE"}, bus.stallCountE, model_cnt);
`endif
  endtask

  // One clock: decide from pre-edge inputs, then compare just after the edge.
  task automatic step(input string tag);
    logic fl, acc, pop, stall;
    logic [PW-1:0] din;
    fl    = bus.flushE;
    acc   = bus.validD && (model_q.size() < 2);
    pop   = (model_q.size() > 0) && bus.readyE;
    stall = (model_q.size() > 0) && !bus.readyE;
    din   = cur_p;
    @(posedge clock);
    #1;
    if (fl) begin
      model_q.delete();
      model_cnt = '0;
    end else begin
      if (stall && model_cnt != '1) model_cnt = model_cnt + 1'b1;
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(din);
    end
    compare_all(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    model_clear();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [PW-1:0] pa, pb, pc;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_clear();
    #2;
    check("reset.validE", bus.validE, 1'b0);
    check("reset.readyD", bus.readyD, 1'b1);
    check("reset.payload", obs_payload(), '0);
    @(posedge clock); #2;
    reset = 1'b0;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(W'(i), 8'h11), 1'b1, 1'b0);
      step("stream");
      check("stream.reg1", bus.reg1ContentE, W'(i));
      check("stream.readyD", bus.readyD, 1'b1);
    end

    // Back-pressure into FULL and drain in order.
    do_reset();
    pa = mk(W'(5), 8'h3C);
    pb = mk(W'(6), 8'hC3);
    drive(1'b1, pa, 1'b0, 1'b0); step("bp.a");
    drive(1'b1, pb, 1'b0, 1'b0); step("bp.b");
    check("bp.full.readyD", bus.readyD, 1'b0);
    check("bp.full.reg1", bus.reg1ContentE, W'(5));
    drive(1'b1, mk(W'(9), 8'h01), 1'b0, 1'b0); step("bp.hold");
    check("bp.hold.reg1", bus.reg1ContentE, W'(5));
    drive(1'b0, '0, 1'b1, 1'b0); step("bp.drain1");
    check("bp.drain1.reg1", bus.reg1ContentE, W'(6));
    check("bp.drain1.readyD", bus.readyD, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); step("bp.drain2");
    check("bp.drain2.validE", bus.validE, 1'b0);

    // Flush from FULL with a coincident valid entry.
    drive(1'b1, pa, 1'b0, 1'b0); step("fl.a");
    drive(1'b1, pb, 1'b0, 1'b0); step("fl.b");
    pc = mk(W'(7), 8'hFF);
    drive(1'b1, pc, 1'b1, 1'b1); step("fl.flush");
    check("fl.validE", bus.validE, 1'b0);
    check("fl.zero", obs_payload(), '0);
    check("fl.readyD", bus.readyD, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); step("fl.after");
    check("fl.after.validE", bus.validE, 1'b0);

    // Bubble: control present on D without validD.
    drive(1'b0, mk(W'(3), 8'hFF), 1'b1, 1'b0); step("bubble");
    check("bubble.controlE", bus.controlE, 8'h00);
    check("bubble.validE", bus.validE, 1'b0);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, pa, 1'b0, 1'b0); step("ar.a");
    drive(1'b1, pb, 1'b0, 1'b0); step("ar.b");
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check("ar.validE", bus.validE, 1'b0);
    check("ar.readyD", bus.readyD, 1'b1);
    check("ar.zero", obs_payload(), '0);
    // Release reset mid-cycle with validD high: nothing captured before the edge.
    drive(1'b1, pc, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel.validE", bus.validE, 1'b0);
    step("rel.capture");
    check("rel.reg1", bus.reg1ContentE, W'(7));

`ifdef DEXE_STALL_COUNT_EN
    // Saturating stall counter.
    do_reset();
    drive(1'b1, pa, 1'b0, 1'b0); step("cnt.load");
    for (int i = 0; i < 5; i++) begin
      logic [NW-1:0] exp_c;
      exp_c = (i < 3) ? NW'(i + 1) : NW'(3);
      drive(1'b0, '0, 1'b0, 1'b0); step("cnt.stall");
      check("cnt.value", bus.stallCountE, exp_c);
    end
    drive(1'b0, '0, 1'b0, 1'b1); step("cnt.flush");
    check("cnt.cleared", bus.stallCountE, '0);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), rand_payload(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
